// File: rtl/tm_program_loader.sv
// Program loader for the Turing machine core: buffers a host-written program,
// replays it to the core with shaped Next handshakes, pulses Done, then issues
// single-step or free-running Next pulses until the core reports Compute_done.
module tm_program_loader #(
    parameter int unsigned dw     = 4,
    parameter int unsigned w      = 64,
    parameter int unsigned aw     = $clog2(w),
    parameter int unsigned HOLD   = 2,
    parameter int unsigned GAP    = 2,
    parameter int unsigned PERIOD = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          load_en,
    input  logic [dw-1:0] load_data,
    input  logic [dw-1:0] head_pos,
    input  logic          start,
    input  logic          step,
    input  logic          run_auto,
    input  logic          Compute_done,
    output logic [dw-1:0] input_data,
    output logic          Next,
    output logic          Done,
    output logic          busy,
    output logic          finished,
    output logic [aw:0]   word_count,
    output logic          overflow
);

    // HOLD and GAP never exceed PERIOD, so one width covers every counter.
    localparam int unsigned CW = $clog2(PERIOD + 1);

    typedef enum logic [2:0] {
        StIdle, StStreamHi, StStreamLo, StDoneP,
        StRunIdle, StStepHi, StStepLo, StFinished
    } state_e;

    state_e          state;
    logic [dw-1:0]   mem [w];
    logic [aw-1:0]   rd_ptr;
    logic [aw-1:0]   rd_next;
    logic [CW-1:0]   phase_cnt;
    logic [CW-1:0]   period_cnt;
    logic [dw-1:0]   data_q;
    logic            full;
    logic            last_word;
    logic            wr_en;

    assign full      = (word_count == (aw+1)'(w));
    assign last_word = ({1'b0, rd_ptr} == (word_count - (aw+1)'(1)));
    assign rd_next   = rd_ptr + 1'b1;
    // start outranks clear and load_en; a full buffer drops the write.
    assign wr_en     = (state == StIdle) && load_en && !start && !clear && !full;

    // Head position is shown live while idle; afterwards the last streamed word holds.
    assign input_data = (state == StIdle) ? head_pos : data_q;
    assign busy       = (state != StIdle) && (state != StFinished);
    assign finished   = (state == StFinished);

    // Program buffer storage; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[word_count[aw-1:0]] <= load_data;
        end
    end

    // Sequencer: buffer bookkeeping, streaming, stepping and registered Next/Done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            word_count <= '0;
            overflow   <= 1'b0;
            rd_ptr     <= '0;
            phase_cnt  <= '0;
            period_cnt <= '0;
            data_q     <= '0;
            Next       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            if (period_cnt != '0) begin
                period_cnt <= period_cnt - 1'b1;
            end
            case (state)
                StIdle: begin
                    if (start) begin
                        rd_ptr <= '0;
                        if (word_count == '0) begin
                            state <= StDoneP;
                            Done  <= 1'b1;
                        end else begin
                            state     <= StStreamHi;
                            Next      <= 1'b1;
                            data_q    <= mem[0];
                            phase_cnt <= CW'(HOLD - 1);
                        end
                    end else if (clear) begin
                        word_count <= '0;
                        overflow   <= 1'b0;
                    end else if (load_en) begin
                        if (full) begin
                            overflow <= 1'b1;
                        end else begin
                            word_count <= word_count + 1'b1;
                        end
                    end
                end
                StStreamHi: begin
                    if (phase_cnt == '0) begin
                        state     <= StStreamLo;
                        Next      <= 1'b0;
                        phase_cnt <= CW'(GAP - 1);
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                StStreamLo: begin
                    if (phase_cnt == '0) begin
                        rd_ptr <= rd_next;
                        if (last_word) begin
                            state <= StDoneP;
                            Done  <= 1'b1;
                        end else begin
                            state     <= StStreamHi;
                            Next      <= 1'b1;
                            data_q    <= mem[rd_next];
                            phase_cnt <= CW'(HOLD - 1);
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                StDoneP: begin
                    state <= StRunIdle;
                    Done  <= 1'b0;
                end
                StRunIdle: begin
                    if (Compute_done) begin
                        state <= StFinished;
                    end else if (step || (run_auto && period_cnt == '0)) begin
                        state      <= StStepHi;
                        Next       <= 1'b1;
                        phase_cnt  <= CW'(HOLD - 1);
                        period_cnt <= CW'(PERIOD - 1);
                    end
                end
                StStepHi: begin
                    if (phase_cnt == '0) begin
                        state     <= StStepLo;
                        Next      <= 1'b0;
                        phase_cnt <= CW'(GAP - 1);
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                StStepLo: begin
                    if (phase_cnt == '0) begin
                        state <= StRunIdle;
                    end else begin
                        phase_cnt <= phase_cnt - 1'b1;
                    end
                end
                StFinished: begin
                    Next <= 1'b0;
                    Done <= 1'b0;
                    if (start) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                    Next  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tm_program_loader.md
Name: tm_program_loader

Overview:
- Upstream stage of the Turing machine core. Drives the core's input_data, Next and Done pins.
- Buffers a program (tape head position, then a word stream) written by the host, replays it with correctly shaped Next high/low handshakes, then pulses Done.
- After Done, issues single-step or free-running Next pulses until the core raises Compute_done.

Parameters:
- dw, 4: word width; matches the core's input_data width.
- w, 64: buffer depth in words.
- aw, $clog2(w): buffer address width.
- HOLD, 2: cycles Next stays high per pulse (≥1).
- GAP, 2: cycles Next stays low after each pulse (≥1).
- PERIOD, 16: free-run spacing between step pulse starts, in cycles (≥ HOLD+GAP).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous: empties the buffer and clears overflow; honoured only in IDLE.
- load_en  in  1  writes load_data into the buffer this cycle; honoured only in IDLE.
- load_data  in  dw  program word to buffer.
- head_pos  in  dw  initial tape head value, presented to the core while IDLE.
- start  in  1  one-cycle request to stream the buffer; honoured only in IDLE.
- step  in  1  one-cycle request for one compute step pulse.
- run_auto  in  1  level: free-run step pulses every PERIOD cycles.
- Compute_done  in  1  from the core; level.
- input_data  out  dw  word to the core.
- Next  out  1  handshake to the core; registered.
- Done  out  1  end-of-program pulse to the core; registered.
- busy  out  1  high in every state except IDLE and FINISHED.
- finished  out  1  high in FINISHED.
- word_count  out  aw+1  number of buffered words (0..w).
- overflow  out  1  sticky: a write was attempted while the buffer was full.

Behaviour:
- Reset (async):
  - State is IDLE; Next=0, Done=0, word_count=0, overflow=0, read pointer=0.
  - input_data=head_pos, because it is combinational in IDLE.
- IDLE:
  - input_data=head_pos.
  - load_en writes buf[word_count] and increments word_count.
  - When word_count==w, the write is dropped and overflow is set.
  - clear takes priority over load_en.
  - start goes to STREAM_HI with rd_ptr=0; if word_count==0 it goes straight to DONE_P.
  - start has priority over a same-cycle load_en; that write is dropped.
- STREAM_HI:
  - Next=1 and input_data=buf[rd_ptr] for HOLD cycles, then STREAM_LO.
  - input_data changes only on the cycle Next rises.
- STREAM_LO:
  - Next=0 and input_data is held for GAP cycles.
  - Then rd_ptr++. If rd_ptr == word_count-1 before the increment, go to DONE_P; else go to STREAM_HI.
- DONE_P: Done=1 for exactly one cycle (Next=0), then RUN_IDLE.
- RUN_IDLE:
  - If Compute_done=1, go to FINISHED; this check takes priority over any step request.
  - Otherwise step=1, or run_auto=1 with the period counter expired, goes to STEP_HI.
  - The period counter reloads to PERIOD-1 on every STEP_HI entry and decrements each cycle, saturating at 0.
- STEP_HI: Next=1 for HOLD cycles, then STEP_LO.
- STEP_LO: Next=0 for GAP cycles, then RUN_IDLE.
- step asserted during STEP_HI or STEP_LO is ignored; there is no queuing.
- Compute_done during STEP_HI or STEP_LO: the pulse completes in full and is acted on in RUN_IDLE.
- FINISHED:
  - Next=0, Done=0, finished=1.
  - Leaves only when start=1, which returns to IDLE. The buffer is preserved so the program can be replayed.
- In all non-IDLE states:
  - input_data holds its last streamed word.
  - load_en and clear are ignored; overflow is unaffected.
- Reset mid-operation returns to IDLE immediately with Next=0 and Done=0 asynchronously. Buffer contents are don't-care; word_count=0.
- Next and Done are never high in the same cycle.
- Next always has at least GAP low cycles between consecutive high phases.

Test Plan:
1. Reset, head_pos=5, load words 3,1,2 → input_data=5 in IDLE, word_count=3; after start, Next has three high phases of 2 cycles each, spaced by 2 low cycles, with input_data=3,1,2. Done pulses for 1 cycle 2 cycles after the last Next falls.
2. Load 64 words, then a 65th with load_en → word_count=64, overflow=1; clear → word_count=0, overflow=0.
3. start with an empty buffer → no Next activity; Done high on the cycle after start, then RUN_IDLE with busy=1.
4. After Done: step for 1 cycle → exactly one Next pulse of 2 high and 2 low cycles. step reasserted during STEP_HI → no extra pulse.
5. run_auto=1 → Next rising edges exactly 16 cycles apart. Compute_done raised during STEP_HI → the pulse completes, then finished=1, busy=0, and Next stays 0 afterwards.
6. Assert reset asynchronously mid-STREAM_HI → Next drops before the next clock edge, state is IDLE, word_count=0; a subsequent load and start stream correctly.
